clk_freq_meter: RTL and testbench
=================================

// Module: clk_freq_meter
// PURPOSE
//   Measures the frequency of a PLL-generated (pre-divided) clock against the system clock.
//   Counts rising edges of async input sig_in over a fixed gate window of GATE_CYCLES clk cycles.
//   Publishes each window's count plus range, overflow and no-signal flags.
//   Sits beside the PLL instances at top level; lets board bring-up confirm 65MHz/18.432MHz outputs.
//   sig_in must be divided down in its own domain (toggle divider) to <= clk/4.
// PARAMETERS
//   GATE_CYCLES  25000000  gate window length in clk cycles (>= 4)
//   CNT_W        24        width of edge counter and count output
//   EXP_MIN      0         lowest count reported as in range (inclusive)
//   EXP_MAX      2**24-1   highest count reported as in range (inclusive)
// PORTS
//   clk          in   1      system clock (e.g. 25MHz board oscillator)
//   reset        in   1      synchronous, active-high reset
//   enable       in   1      1 = measure continuously; 0 = hold gate/edge counters at zero
//   sig_in       in   1      asynchronous signal to measure
//   count        out  CNT_W  rising edges in last completed window
//   count_valid  out  1      one-cycle pulse when count/flags update
//   overflow     out  1      last window's edge counter saturated
//   no_signal    out  1      last window saw zero edges
//   in_range     out  1      EXP_MIN <= count <= EXP_MAX and !overflow
// BEHAVIOUR
//   - Reset: count=0, count_valid=0, overflow=0, no_signal=0, in_range=0.
//     Reset also clears both synchronizer flops, edge-detect reg, edge counter and gate counter.
//   - Synchronizer: 2 flops (s1,s2) then s3 for edge detect; edge = s2 & ~s3.
//     A sig_in rise settled before clk edge N gives edge=1 in the cycle after edge N+1.
//   - Gate counter: runs 0..GATE_CYCLES-1 while enable=1; terminal cycle = GATE_CYCLES-1.
//   - Edge counter: +1 per cycle with edge=1; saturates at 2**CNT_W-1, sets internal sat bit.
//   - Terminal cycle (registered at next clk edge):
//     - count <= edge_cnt + edge (saturating); an edge in the terminal cycle belongs to this window.
//     - overflow <= sat bit, or the terminal increment saturates.
//     - no_signal <= (final count == 0).
//     - in_range recomputed from the new values.
//     - count_valid=1 for exactly that one cycle.
//     - edge_cnt <= 0, sat <= 0, gate <= 0; the next window starts immediately with no dead cycle.
//   - First count_valid after reset/enable rise: GATE_CYCLES cycles after the first enabled cycle.
//   - enable=0 mid-window: the window is discarded; gate and edge counters clear next cycle.
//     count/flags hold their last values; no count_valid.
//     Synchronizer keeps running so no false edge appears on re-enable.
//   - count and flags change only on count_valid cycles (or reset).
//   - Reset asserted mid-window: abort, all outputs return to reset values next cycle.
// TESTING
//   (bench: GATE_CYCLES=100, CNT_W=8, EXP_MIN=20, EXP_MAX=30)
//   1. sig_in period 4 clk, enable=1 -> count_valid pulses every 100 cycles; count=25;
//      in_range=1; overflow=0; no_signal=0.
//   2. sig_in held 0 -> count=0, no_signal=1, in_range=0 on each pulse.
//   3. CNT_W=4, sig_in period 4 -> count=15, overflow=1, in_range=0; next window re-evaluates clean.
//   4. Single sig_in rise timed to land edge in terminal cycle -> counted in that window (count=1).
//      Next window count=0.
//   5. enable dropped at cycle 50 for 10 cycles -> no pulse at cycle 100; count holds.
//      Next pulse 100 cycles after re-enable.
//   6. reset at cycle 60 of a window -> outputs 0 next cycle; first pulse 100 cycles after release.

Source files
------------

// File: rtl/clk_freq_meter.sv
// clk_freq_meter: counts rising edges of async sig_in over a GATE_CYCLES-clk window and publishes
// each window's count with overflow, no-signal and in-range flags.
module clk_freq_meter #(
  parameter int unsigned GATE_CYCLES = 25000000,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned EXP_MIN     = 0,
  parameter int unsigned EXP_MAX     = 2**24-1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             overflow,
  output logic             no_signal,
  output logic             in_range
);
  localparam int unsigned       GW        = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]     GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [GW-1:0]    gate_q, gate_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             overflow_q, overflow_d;
  logic             no_signal_q, no_signal_d;
  logic             in_range_q, in_range_d;
  logic             edge_det, term, lost, win_ovf;
  logic [CNT_W-1:0] edge_sum;
  always_comb begin
    s1_d        = sig_in;
    s2_d        = s1_q;
    s3_d        = s2_q;
    edge_det    = s2_q & ~s3_q;
    term        = enable & (gate_q == GATE_LAST);
    // an edge arriving while the counter already sits at full scale is lost
    lost        = edge_det & (edge_cnt_q == CNT_MAX);
    win_ovf     = sat_q | lost;
    edge_sum    = edge_cnt_q + CNT_W'(edge_det & ~lost);
    gate_d      = (!enable || term) ? '0 : gate_q + 1'b1;
    edge_cnt_d  = (!enable || term) ? '0 : edge_sum;
    sat_d       = enable & ~term & win_ovf;
    valid_d     = term;
    count_d     = term ? edge_sum : count_q;
    overflow_d  = term ? win_ovf : overflow_q;
    no_signal_d = term ? (edge_sum == '0) : no_signal_q;
    in_range_d  = term ? ((32'(edge_sum) + 32'd1 > EXP_MIN) && (32'(edge_sum) <= EXP_MAX) && !win_ovf)
                       : in_range_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      gate_q      <= '0;
      edge_cnt_q  <= '0;
      sat_q       <= 1'b0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      no_signal_q <= 1'b0;
      in_range_q  <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      gate_q      <= gate_d;
      edge_cnt_q  <= edge_cnt_d;
      sat_q       <= sat_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      no_signal_q <= no_signal_d;
      in_range_q  <= in_range_d;
    end
  end
  assign count       = count_q;
  assign count_valid = valid_q;
  assign overflow    = overflow_q;
  assign no_signal   = no_signal_q;
  assign in_range    = in_range_q;
endmodule

// File: tb/tb_clk_freq_meter.sv
// tb_clk_freq_meter: table, directed and random checks of clk_freq_meter (8-bit and 4-bit counters)
// against a window-level edge-count model.
module tb_clk_freq_meter;
  localparam int G = 100;
  logic       clk = 1'b0, reset = 1'b1, enable = 1'b0, sig_in = 1'b0;
  logic [7:0] cnt8;
  logic [3:0] cnt4;
  logic       cv8, ov8, ns8, ir8, cv4, ov4, ns4, ir4;
  int asserts = 0, fails = 0;
  bit hist[$];
  int win = 0, n = 0;
  int e_cv = 0, e_c8 = 0, e_ov8 = 0, e_ns = 0, e_ir8 = 0, e_c4 = 0, e_ov4 = 0, e_ir4 = 0;

  typedef struct {
    int period;
    int nrise;
    int c8;
    int ns;
    int ir8;
    int c4;
    int ov4;
  } row_t;
  row_t rows[9];

  always #5 clk = ~clk;

  clk_freq_meter #(.GATE_CYCLES(G), .CNT_W(8), .EXP_MIN(20), .EXP_MAX(30)) dut8 (
    .clk(clk), .reset(reset), .enable(enable), .sig_in(sig_in),
    .count(cnt8), .count_valid(cv8), .overflow(ov8), .no_signal(ns8), .in_range(ir8)
  );

  clk_freq_meter #(.GATE_CYCLES(G), .CNT_W(4), .EXP_MIN(20), .EXP_MAX(30)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .sig_in(sig_in),
    .count(cnt4), .count_valid(cv4), .overflow(ov4), .no_signal(ns4), .in_range(ir4)
  );

  function automatic void chk(input string name, input int act, input int exp);
    asserts++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // square wave of the given period (high for the first half), limited to nr rising edges
  function automatic bit pat(input int p, input int nr, input int k);
    return p != 0 && k < nr * p && (k % p) < p / 2;
  endfunction

  // drive one cycle, advance the model, then compare both DUTs after the clock edge
  task automatic step(input bit r, input bit en, input bit s);
    bit e;
    @(negedge clk);
    reset = r;
    enable = en;
    sig_in = s;
    hist.push_back(s);
    e = hist[hist.size()-3] && !hist[hist.size()-4];
    hist.pop_front();
    e_cv = 0;
    if (r) begin
      hist = '{1'b0, 1'b0, 1'b0};
      win = 0; n = 0;
      e_c8 = 0; e_ov8 = 0; e_ns = 0; e_ir8 = 0; e_c4 = 0; e_ov4 = 0; e_ir4 = 0;
    end else if (!en) begin
      win = 0; n = 0;
    end else begin
      n += int'(e);
      if (win == G - 1) begin
        e_cv  = 1;
        e_c8  = n > 255 ? 255 : n;
        e_ov8 = int'(n > 255);
        e_ns  = int'(n == 0);
        e_ir8 = int'(e_c8 >= 20 && e_c8 <= 30 && e_ov8 == 0);
        e_c4  = n > 15 ? 15 : n;
        e_ov4 = int'(n > 15);
        e_ir4 = int'(e_c4 >= 20 && e_c4 <= 30 && e_ov4 == 0);
        win = 0; n = 0;
      end else win++;
    end
    @(posedge clk);
    #1;
    chk("valid8", int'(cv8), e_cv);
    chk("count8", int'(cnt8), e_c8);
    chk("overflow8", int'(ov8), e_ov8);
    chk("no_signal8", int'(ns8), e_ns);
    chk("in_range8", int'(ir8), e_ir8);
    chk("valid4", int'(cv4), e_cv);
    chk("count4", int'(cnt4), e_c4);
    chk("overflow4", int'(ov4), e_ov4);
    chk("no_signal4", int'(ns4), e_ns);
    chk("in_range4", int'(ir4), e_ir4);
  endtask

  task automatic run_row(input row_t rw, input int idx);
    int seen = 0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 150 && seen == 0; k++) begin
      step(1'b0, 1'b1, pat(rw.period, rw.nrise, k));
      if (cv8) begin
        seen = 1;
        chk($sformatf("row%0d_pulse_cycle", idx), k, G - 1);
        chk($sformatf("row%0d_count8", idx), int'(cnt8), rw.c8);
        chk($sformatf("row%0d_no_signal", idx), int'(ns8), rw.ns);
        chk($sformatf("row%0d_in_range8", idx), int'(ir8), rw.ir8);
        chk($sformatf("row%0d_count4", idx), int'(cnt4), rw.c4);
        chk($sformatf("row%0d_overflow4", idx), int'(ov4), rw.ov4);
      end
    end
    chk($sformatf("row%0d_pulse_seen", idx), seen, 1);
  endtask

  initial begin
    int pulses, p1, p2, seen, mode;
    bit s;
    rows[0] = '{4, 1000, 25, 0, 1, 15, 1};
    rows[1] = '{0, 0, 0, 1, 0, 0, 0};
    rows[2] = '{5, 1000, 20, 0, 1, 15, 1};
    rows[3] = '{10, 1000, 10, 0, 0, 10, 0};
    rows[4] = '{3, 30, 30, 0, 1, 15, 1};
    rows[5] = '{3, 31, 31, 0, 0, 15, 1};
    rows[6] = '{4, 19, 19, 0, 0, 15, 1};
    rows[7] = '{4, 15, 15, 0, 0, 15, 0};
    rows[8] = '{4, 16, 16, 0, 0, 15, 1};
    hist = '{1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 9; i++) run_row(rows[i], i);

    // an edge landing in the terminal cycle belongs to the closing window
    step(1'b1, 1'b0, 1'b0);
    pulses = 0;
    for (int k = 0; k < 200; k++) begin
      step(1'b0, 1'b1, k >= 97);
      if (cv8) begin
        pulses++;
        if (pulses == 1) begin
          chk("term_cycle", k, 99);
          chk("term_count", int'(cnt8), 1);
        end else begin
          chk("next_count", int'(cnt8), 0);
          chk("next_no_signal", int'(ns8), 1);
        end
      end
    end
    chk("term_pulses", pulses, 2);

    // enable dropped mid-window discards it and restarts the gate on re-enable
    step(1'b1, 1'b0, 1'b0);
    pulses = 0; p1 = -1; p2 = -1;
    for (int k = 0; k <= 300; k++) begin
      step(1'b0, !(k >= 150 && k < 160), pat(4, 1000, k));
      if (cv8) begin
        pulses++;
        if (pulses == 1) p1 = k; else p2 = k;
      end
      if (k == 155) chk("hold_count", int'(cnt8), 25);
    end
    chk("drop_pulses", pulses, 2);
    chk("drop_first", p1, 99);
    chk("drop_reenable", p2, 259);

    // reset 60 cycles into a window
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 160; k++) step(1'b0, 1'b1, pat(4, 1000, k));
    chk("pre_rst_count", int'(cnt8), 25);
    step(1'b1, 1'b1, pat(4, 1000, 160));
    chk("rst_count", int'(cnt8), 0);
    chk("rst_in_range", int'(ir8), 0);
    seen = -1;
    for (int k = 0; k < 120; k++) begin
      step(1'b0, 1'b1, pat(4, 1000, k));
      if (cv8 && seen < 0) seen = k;
    end
    chk("rst_first_pulse", seen, 99);

    // random patterns, enable drops and resets against the model
    step(1'b1, 1'b0, 1'b0);
    mode = 0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 299) == 0) mode = $urandom_range(0, 5);
      case (mode)
        0:       s = 1'b0;
        1:       s = pat(4, 1 << 20, k);
        2:       s = pat(5, 1 << 20, k);
        3:       s = pat(7, 1 << 20, k);
        4:       s = pat(9, 1 << 20, k);
        default: s = $urandom_range(0, 3) == 0;
      endcase
      step($urandom_range(0, 1999) == 0, $urandom_range(0, 499) != 0, s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
